// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of the single-port framebuffer ram.
// Reader has priority; a pending write is forced through after MAX_WAIT losses.
module ram_arbiter #(
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 98304,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_w_enable,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              err_oob
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);
    // One extra bit so a DEPTH of 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

    logic [CW-1:0] wait_q, wait_d;
    logic          rd_valid_q;
    logic          oob_rd_q, oob_rd_d;
    logic          err_oob_q, err_oob_d;
    logic          force_wr;
    logic          wr_oob;
    logic          rd_oob;

    assign wr_oob   = {1'b0, wr_addr} >= LIMIT;
    assign rd_oob   = {1'b0, rd_addr} >= LIMIT;
    assign force_wr = wr_req && (wait_q >= WAIT_MAX);

    // Grants are gated by reset so nothing reaches ram while held in reset.
    assign wr_ack = reset && wr_req && (!rd_req || force_wr);
    assign rd_ack = reset && rd_req && !wr_ack;

    assign ram_addr     = wr_ack ? wr_addr : rd_addr;
    assign ram_wdata    = wr_ack ? wr_data : '0;
    assign ram_w_enable = wr_ack && !wr_oob;

    always_comb begin
        wait_d = wait_q;
        if (!wr_req || wr_ack) begin
            wait_d = '0;
        end else if (wait_q < WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
        end
    end

    assign oob_rd_d  = rd_ack && rd_oob;
    assign err_oob_d = (wr_ack && wr_oob) || oob_rd_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q     <= '0;
            rd_valid_q <= 1'b0;
            oob_rd_q   <= 1'b0;
            err_oob_q  <= 1'b0;
        end else begin
            wait_q     <= wait_d;
            rd_valid_q <= rd_ack;
            oob_rd_q   <= oob_rd_d;
            err_oob_q  <= err_oob_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign err_oob  = err_oob_q;
    assign rd_data  = (rd_valid_q && !oob_rd_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: shadow-memory reference model,
// directed edge cases followed by randomized contention traffic.
module tb_ram_arbiter;

    localparam int DEPTH    = 98304;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req;
    logic [16:0] rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        wr_req;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic [16:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_w_enable;
    logic [7:0]  ram_rdata;
    logic        err_oob;

    ram_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_ack       (rd_ack),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ack       (wr_ack),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_w_enable (ram_w_enable),
        .ram_rdata    (ram_rdata),
        .err_oob      (err_oob)
    );

    always #5 clk = ~clk;

    // Synchronous-read ram behind the arbiter.
    bit [7:0] mem [131072];
    always @(posedge clk) begin
        if (ram_w_enable) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int nchk = 0;
    int nerr = 0;
    bit [7:0] sh [131072];
    int lost = 0;
    bit mon_on = 1'b0;
    int rd_q[$];
    int err_q[$];
    bit last_w;

    function automatic void chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // One bus cycle: drive, check grants against the rule, record expectations.
    task automatic cycle(input bit rq, input logic [16:0] ra,
                         input bit wq, input logic [16:0] wa,
                         input logic [7:0] wd);
        bit ew, er;
        @(negedge clk);
        rd_req = rq; rd_addr = ra;
        wr_req = wq; wr_addr = wa; wr_data = wd;
        #1;
        ew = wq && (!rq || lost >= MAX_WAIT);
        er = rq && !ew;
        chk("wr_ack", int'(wr_ack), int'(ew));
        chk("rd_ack", int'(rd_ack), int'(er));
        chk("ram_w_enable", int'(ram_w_enable), int'(ew && int'(wa) < DEPTH));
        if (ew) begin
            if (int'(wa) < DEPTH) sh[wa] = wd;
            err_q.push_back(int'(int'(wa) >= DEPTH));
        end else if (er) begin
            rd_q.push_back(int'(ra) < DEPTH ? int'(sh[ra]) : 0);
            err_q.push_back(int'(int'(ra) >= DEPTH));
        end else begin
            err_q.push_back(0);
        end
        lost = (wq && !ew) ? lost + 1 : 0;
        last_w = ew;
    endtask

    task automatic idle();
        cycle(1'b0, 17'h0, 1'b0, 17'h0, 8'h0);
    endtask

    function automatic logic [16:0] pick();
        logic [16:0] a;
        case ($urandom_range(0, 5))
            0, 1: a = 17'h00010 + 17'($urandom_range(0, 7));
            2: a = 17'h07FFF + 17'($urandom_range(0, 1));
            3: a = 17'h0FFFF + 17'($urandom_range(0, 1));
            4: a = 17'h17FF8 + 17'($urandom_range(0, 7));
            default: a = 17'h18000 + 17'($urandom_range(0, 31));
        endcase
        return a;
    endfunction

    // Monitor: pops expectations whenever registered outputs are presented.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (mon_on) begin
                if (rd_valid) begin
                    if (rd_q.size() == 0) begin
                        chk("rd_valid_unexpected", 1, 0);
                    end else begin
                        chk("rd_data", int'(rd_data), rd_q.pop_front());
                    end
                end else begin
                    chk("rd_data_idle", int'(rd_data), 0);
                end
                if (err_q.size() != 0) begin
                    chk("err_oob", int'(err_oob), err_q.pop_front());
                end else if (err_oob) begin
                    chk("err_oob_spurious", 1, 0);
                end
            end
        end
    end

    logic [16:0] edge_a [5];
    logic [7:0]  edge_d [5];
    bit          pr, pw;
    logic [16:0] pra, pwa;
    logic [7:0]  pwd;

    initial begin
        reset = 1'b0;
        rd_req = 1'b1; rd_addr = 17'h10;
        wr_req = 1'b1; wr_addr = 17'h10; wr_data = 8'h5A;
        #12;
        chk("rst_rd_ack", int'(rd_ack), 0);
        chk("rst_wr_ack", int'(wr_ack), 0);
        chk("rst_wen", int'(ram_w_enable), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_err_oob", int'(err_oob), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0;
        reset = 1'b1;
        mon_on = 1'b1;

        cycle(1'b0, 17'h0, 1'b1, 17'h00010, 8'hA5);
        cycle(1'b1, 17'h00010, 1'b0, 17'h0, 8'h0);
        idle();

        // Continuous contention: write wins every fifth cycle.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 17'h00100 + 17'(i), 1'b1, 17'h00200, 8'h3C);
            chk("contention_pattern", int'(last_w), int'(i % 5 == 4));
        end
        idle();

        edge_a[0] = 17'h07FFF; edge_d[0] = 8'h11;
        edge_a[1] = 17'h08000; edge_d[1] = 8'h22;
        edge_a[2] = 17'h0FFFF; edge_d[2] = 8'h33;
        edge_a[3] = 17'h10000; edge_d[3] = 8'h44;
        edge_a[4] = 17'h17FFF; edge_d[4] = 8'h55;
        for (int i = 0; i < 5; i++) cycle(1'b0, 17'h0, 1'b1, edge_a[i], edge_d[i]);
        for (int i = 0; i < 5; i++) cycle(1'b1, edge_a[i], 1'b0, 17'h0, 8'h0);
        idle();

        cycle(1'b0, 17'h0, 1'b1, 17'h18000, 8'hFF);
        cycle(1'b1, 17'h1FFFF, 1'b0, 17'h0, 8'h0);
        idle();
        chk("oob_ram_unchanged", int'(mem[17'h18000]), 0);

        // Build up starvation history, then reset right after a read grant.
        for (int i = 0; i < 4; i++) cycle(1'b1, 17'h00010, 1'b1, 17'h00020, 8'h77);
        @(posedge clk);
        #3;
        chk("rd_valid_before_rst", int'(rd_valid), 1);
        reset = 1'b0;
        #1;
        chk("rd_valid_async_clr", int'(rd_valid), 0);
        chk("rd_ack_in_rst", int'(rd_ack), 0);
        mon_on = 1'b0;
        rd_q.delete();
        err_q.delete();
        lost = 0;
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0;
        reset = 1'b1;
        mon_on = 1'b1;
        cycle(1'b0, 17'h0, 1'b1, 17'h00020, 8'h66);
        chk("lone_wr_first_cycle", int'(last_w), 1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 17'h00020, 1'b1, 17'h00021, 8'h99);
            chk("post_rst_wait", int'(last_w), int'(i == 4));
        end
        idle();

        pr = 1'b0; pw = 1'b0;
        pra = '0; pwa = '0; pwd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pr || $urandom_range(0, 9) == 0) begin
                pr = ($urandom_range(0, 2) != 0);
                pra = pick();
            end
            if (!pw || $urandom_range(0, 9) == 0) begin
                pw = ($urandom_range(0, 2) == 0);
                pwa = pick();
                pwd = 8'($urandom);
            end
            cycle(pr, pra, pw, pwa, pwd);
            if (last_w) pw = 1'b0;
            else if (pr) pr = 1'b0;
        end
        idle();
        idle();
        @(posedge clk);
        #3;
        chk("rd_queue_drained", rd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
